// File: rtl/match_sequencer.sv
// match_sequencer
//   Game-level controller for the LED ping-pong datapath. Walks each match
//   through idle, serve wait, rally, point pause and match over; keeps the
//   scores, serve rotation and speed level; gates the ball engine.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   tick         one-cycle game-rate enable
//   start        start / restart a match (IDLE or OVER only)
//   lvl_up       raise speed level (IDLE or OVER only)
//   lvl_down     lower speed level (IDLE or OVER only)
//   serve_btn    current server's hit
//   p1_point     ball engine awards a point to P1
//   p2_point     ball engine awards a point to P2
//   level        speed level to the clock selector
//   game_run     ball engine enable
//   serve_start  one-cycle launch pulse to the ball engine
//   server       0 = P1 serves, 1 = P2 serves
//   score_p1     P1 score
//   score_p2     P2 score
//   winner       00 none, 01 P1, 10 P2
//   blink        display blink flag
//   state_o      IDLE=0, SERVE_WAIT=1, RALLY=2, PAUSE=3, OVER=4

module match_sequencer #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_SWAP  = 2,
  parameter int PAUSE_TICKS = 8,
  parameter int SERVE_TO    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       lvl_up,
  input  logic       lvl_down,
  input  logic       serve_btn,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [1:0] level,
  output logic       game_run,
  output logic       serve_start,
  output logic       server,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic       blink,
  output logic [2:0] state_o
);

  localparam int TW = (SERVE_TO    < 2) ? 1 : $clog2(SERVE_TO + 1);
  localparam int PW = (PAUSE_TICKS < 2) ? 1 : $clog2(PAUSE_TICKS + 1);
  localparam int CW = (SERVE_SWAP  < 2) ? 1 : $clog2(SERVE_SWAP + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    RALLY      = 3'd2,
    PAUSE      = 3'd3,
    OVER       = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [1:0]    level_n;
  logic [3:0]    score_p1_n, score_p2_n;
  logic          server_n;
  logic [1:0]    winner_n;
  logic          blink_n;
  logic          game_run_n;
  logic          serve_start_n;
  logic [CW-1:0] point_cnt, point_cnt_n, point_inc;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic [PW-1:0] pause_cnt, pause_cnt_n;

  logic          begin_match;
  logic          p1_only, p2_only;
  logic          serve_timeout;
  logic          pause_done;
  logic          deuce;
  logic          scorer_wins;
  logic [4:0]    new_p1, new_p2, new_mine, new_theirs;

  assign begin_match = start && (state == IDLE || state == OVER);

  // Simultaneous point pulses are a ball-engine fault and score nothing.
  assign p1_only = p1_point && !p2_point;
  assign p2_only = p2_point && !p1_point;

  // The timeout fires on the SERVE_TO-th tick itself, so a serve_btn in the
  // same cycle merges into the same single launch.
  assign serve_timeout = (SERVE_TO != 0) && tick && (tick_cnt == TW'(SERVE_TO - 1));
  assign pause_done    = tick && (pause_cnt == PW'(PAUSE_TICKS - 1));

  // Scores are widened by one bit so the lead test cannot wrap.
  assign new_p1     = {1'b0, score_p1} + {4'd0, p1_only};
  assign new_p2     = {1'b0, score_p2} + {4'd0, p2_only};
  assign new_mine   = p1_only ? new_p1 : new_p2;
  assign new_theirs = p1_only ? new_p2 : new_p1;

  assign scorer_wins = ((new_mine >= 5'(WIN_SCORE)) && (new_mine >= new_theirs + 5'd2))
                       || (new_mine == 5'd15);
  assign deuce       = (new_p1 >= 5'(WIN_SCORE - 1)) && (new_p2 >= 5'(WIN_SCORE - 1));
  assign point_inc   = point_cnt + CW'(1);

  always_comb begin
    state_n       = state;
    level_n       = level;
    score_p1_n    = score_p1;
    score_p2_n    = score_p2;
    server_n      = server;
    winner_n      = winner;
    blink_n       = blink;
    serve_start_n = 1'b0;
    point_cnt_n   = point_cnt;
    tick_cnt_n    = tick_cnt;
    pause_cnt_n   = pause_cnt;

    // Opposing level requests in one cycle cancel out.
    if ((state == IDLE || state == OVER) && (lvl_up != lvl_down)) begin
      if (lvl_up && level != 2'd3) begin
        level_n = level + 2'd1;
      end else if (lvl_down && level != 2'd0) begin
        level_n = level - 2'd1;
      end
    end

    case (state)
      IDLE: begin
      end

      SERVE_WAIT: begin
        if (serve_btn || serve_timeout) begin
          state_n       = RALLY;
          serve_start_n = 1'b1;
        end else if (tick) begin
          tick_cnt_n = tick_cnt + TW'(1);
        end
      end

      RALLY: begin
        if (p1_only || p2_only) begin
          score_p1_n = new_p1[3:0];
          score_p2_n = new_p2[3:0];
          if (scorer_wins) begin
            winner_n = p1_only ? 2'b01 : 2'b10;
            state_n  = OVER;
          end else begin
            state_n     = PAUSE;
            pause_cnt_n = '0;
            // Deuce is sticky until the match ends, so the rotation
            // counter is simply parked at zero while it lasts.
            if (deuce || point_inc == CW'(SERVE_SWAP)) begin
              server_n    = ~server;
              point_cnt_n = '0;
            end else begin
              point_cnt_n = point_inc;
            end
          end
        end
      end

      PAUSE: begin
        if (tick) begin
          if (pause_done) begin
            state_n    = SERVE_WAIT;
            tick_cnt_n = '0;
          end else begin
            pause_cnt_n = pause_cnt + PW'(1);
          end
        end
      end

      OVER: begin
        if (tick) begin
          blink_n = ~blink;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // A new match overrides the OVER blink toggle in the same cycle.
    if (begin_match) begin
      state_n     = SERVE_WAIT;
      score_p1_n  = 4'd0;
      score_p2_n  = 4'd0;
      server_n    = 1'b0;
      winner_n    = 2'b00;
      blink_n     = 1'b0;
      point_cnt_n = '0;
      tick_cnt_n  = '0;
    end

    game_run_n = (state_n == RALLY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      level       <= 2'd0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      server      <= 1'b0;
      winner      <= 2'b00;
      blink       <= 1'b0;
      game_run    <= 1'b0;
      serve_start <= 1'b0;
      point_cnt   <= '0;
      tick_cnt    <= '0;
      pause_cnt   <= '0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      score_p1    <= score_p1_n;
      score_p2    <= score_p2_n;
      server      <= server_n;
      winner      <= winner_n;
      blink       <= blink_n;
      game_run    <= game_run_n;
      serve_start <= serve_start_n;
      point_cnt   <= point_cnt_n;
      tick_cnt    <= tick_cnt_n;
      pause_cnt   <= pause_cnt_n;
    end
  end

  assign state_o = state;

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Game-level controller for the LED ping-pong datapath. It sequences each match through the phases idle, serve, rally, point pause and match over. It owns the scores, serve rotation and speed-level selection, and it gates the ball datapath through game_run and serve_start. It sits between the debounced buttons and switches and the ball engine, and takes point events back from the ball engine.

Parameters:
WIN_SCORE, 11, points needed to win; win-by-2 applies; range 2..14
SERVE_SWAP, 2, total points played between server changes outside deuce
PAUSE_TICKS, 8, tick pulses spent in point pause
SERVE_TO, 32, ticks in SERVE_WAIT before an automatic serve; 0 disables auto-serve

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
tick  in  1  one-cycle game-rate enable from the selected game clock
start  in  1  one-cycle pulse, start or restart a match
lvl_up  in  1  one-cycle pulse, raise speed level
lvl_down  in  1  one-cycle pulse, lower speed level
serve_btn  in  1  one-cycle pulse, current server's hit
p1_point  in  1  one-cycle pulse, ball engine awards point to P1
p2_point  in  1  one-cycle pulse, ball engine awards point to P2
level  out  2  speed level to the clock selector
game_run  out  1  ball engine enable
serve_start  out  1  one-cycle launch pulse to the ball engine
server  out  1  0 = P1 serves, 1 = P2 serves
score_p1  out  4  P1 score
score_p2  out  4  P2 score
winner  out  2  00 none, 01 P1, 10 P2
blink  out  1  display blink flag
state_o  out  3  state code: IDLE=0, SERVE_WAIT=1, RALLY=2, PAUSE=3, OVER=4

Behaviour:
- Reset: the design samples reset on a clk edge with rst_n=0. It sets state IDLE, level=0, both scores 0, server=0, winner=00, blink=0, game_run=0, serve_start=0, and clears all counters. Reset overrides every other input in the same cycle.
- All outputs are registered. State changes take effect on the cycle after the triggering input.
- Level changes:
  - Level changes are accepted only in IDLE or OVER.
  - It saturates at 0 and at 3.
  - lvl_up and lvl_down in the same cycle leave level unchanged.
- IDLE:
  - game_run=0.
  - start clears both scores, sets server=0, winner=00 and the point counter to 0, then moves to SERVE_WAIT.
- SERVE_WAIT:
  - game_run=0. Ticks are counted.
  - serve_btn moves the block to RALLY: serve_start=1 for exactly one cycle, and game_run=1 from the next cycle onward.
  - If SERVE_TO≠0 and the tick counter reaches SERVE_TO, the block auto-serves, identical to serve_btn.
  - If serve_btn and the timeout arrive in the same cycle, only one serve is issued.
- RALLY:
  - game_run=1.
  - Exactly one of p1_point or p2_point increments that player's score, and the block moves to PAUSE with game_run=0 on the next cycle.
  - p1_point and p2_point together are a fault: the block ignores both and stays in RALLY.
  - Point pulses in any other state are ignored.
- Win check, evaluated on the scoring update:
  - The scorer wins if its new score ≥ WIN_SCORE and its lead is ≥ 2, or if its new score = 15 (score cap).
  - On a win, winner is set and the block goes to OVER instead of PAUSE.
- Serve rotation, applied on each non-winning point:
  - The point counter increments.
  - Deuce is defined as both scores ≥ WIN_SCORE−1.
  - In deuce, server toggles on every point.
  - Otherwise server toggles when the counter reaches SERVE_SWAP, and the counter returns to 0.
- PAUSE:
  - game_run=0.
  - After PAUSE_TICKS tick pulses, the block goes to SERVE_WAIT and clears the serve timeout counter.
- OVER:
  - game_run=0, and scores are frozen.
  - blink toggles on each tick.
  - start begins a new match exactly as from IDLE, and blink is cleared.
- Reset mid-rally returns the block to IDLE with the reset values listed above. No serve_start is emitted.
- start in SERVE_WAIT, RALLY or PAUSE is ignored.

Test Plan:
1. Reset, then lvl_up ×5 and lvl_down ×1 in IDLE → level = 2. Then start and lvl_up in SERVE_WAIT → level stays 2.
2. start, serve_btn → serve_start high for exactly 1 cycle and game_run=1. p2_point → score_p2=1, state PAUSE. After 8 ticks → state SERVE_WAIT, server still 0. Next point → server=1.
3. SERVE_WAIT with no serve_btn for 32 ticks → automatic serve_start pulse, state RALLY.
4. Drive scores to 10–10 (deuce): server toggles each point. P1 scores to 11–10 → no winner. P1 scores to 12–10 → winner=01, state OVER, blink toggling on ticks.
5. Alternate points past deuce until P2 reaches 15 with scores 15–14 → winner=10 via the score cap.
6. p1_point and p2_point in the same cycle during RALLY → scores unchanged, still RALLY. rst_n=0 mid-rally → IDLE, scores 0, game_run=0, level=0.
